// File: rtl/act_writeback_packer.sv
// Packs RATIO activation beats into one memory word, buffers words in a
// show-ahead FIFO and streams them out on valid/ready with job completion tracking.
module act_writeback_packer #(
  parameter int N_KERNEL   = 4,
  parameter int B_PIXEL    = 16,
  parameter int B_WORD     = 512,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [15:0]                     n_beats,
  input  logic [N_KERNEL*2*B_PIXEL-1:0]   di,
  input  logic                            di_valid,
  output logic [B_WORD-1:0]               wo,
  output logic                            wo_last,
  output logic                            wo_valid,
  input  logic                            wo_ready,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow
);
  localparam int B_BEAT = N_KERNEL * 2 * B_PIXEL;
  localparam int RATIO  = B_WORD / B_BEAT;
  localparam int IDX_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [15:0]        remain_q, remain_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [B_WORD-1:0]  pack_q, pack_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [B_WORD:0]    mem_q [FIFO_DEPTH];

  logic               full, pop, push, last_c, cmpl, zero_job;
  logic [B_WORD-1:0]  word_c;
  logic [B_WORD:0]    push_data, head;

  always_comb begin
    full   = (count_q == CNT_W'(FIFO_DEPTH));
    pop    = (count_q != '0) && wo_ready;
    head   = mem_q[rptr_q];
    // Upper slots are always zero here because pack is cleared after every word.
    word_c = pack_q;
    for (int r = 0; r < RATIO; r++) begin
      if (idx_q == IDX_W'(r)) word_c[r*B_BEAT +: B_BEAT] = di;
    end
    last_c = (remain_q == 16'd1);
    cmpl   = (idx_q == IDX_W'(RATIO - 1)) || last_c;

    state_d    = state_q;
    remain_d   = remain_q;
    idx_d      = idx_q;
    pack_d     = pack_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    zero_job   = 1'b0;
    push       = 1'b0;
    push_data  = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          overflow_d = 1'b0;
          idx_d      = '0;
          pack_d     = '0;
          remain_d   = n_beats;
          if (n_beats == 16'd0) begin
            done_d   = 1'b1;
            zero_job = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (di_valid) begin
          remain_d = remain_q - 16'd1;
          if (cmpl) begin
            idx_d  = '0;
            pack_d = '0;
            if (!full) begin
              push      = 1'b1;
              push_data = {last_c, word_c};
              if (last_c) state_d = S_DRAIN;
            end else if (last_c) begin
              // The final word is never dropped; park it until space frees up.
              pack_d  = word_c;
              state_d = S_FLUSH;
            end else begin
              overflow_d = 1'b1;
            end
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            pack_d = word_c;
          end
        end
      end
      S_FLUSH: begin
        if (!full) begin
          push      = 1'b1;
          push_data = {1'b1, pack_q};
          pack_d    = '0;
          state_d   = S_DRAIN;
        end
      end
      default: begin
        if (pop && head[B_WORD]) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase

    busy_d = (state_d != S_IDLE) || zero_job;
    wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      remain_q   <= '0;
      idx_q      <= '0;
      pack_q     <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      idx_q      <= idx_d;
      pack_q     <= pack_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  // Storage carries no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

  assign wo_valid = (count_q != '0);
  assign wo       = wo_valid ? head[B_WORD-1:0] : '0;
  assign wo_last  = wo_valid & head[B_WORD];
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
endmodule

// File: doc/act_writeback_packer.md
# act_writeback_packer

Receiving end of the activation unit's output stream in the TPU datapath. Takes `N_KERNEL*2` activated pixels per beat on a valid-only interface (no backpressure), packs `RATIO` beats into one wide memory word and buffers the words in a small FIFO. Words leave on a valid/ready stream toward the DDR write path. The transfer length is programmed per job; the block reports completion, and flags any drops caused by downstream stalls.

## Interface
- `N_KERNEL`, 4: kernels per activation beat
- `B_PIXEL`, 16: bits per pixel
- `B_WORD`, 512: output word width; must be an integer multiple of `B_BEAT = N_KERNEL*2*B_PIXEL`; `RATIO = B_WORD/B_BEAT` (default 4)
- `FIFO_DEPTH`, 8: output FIFO depth in words; power of two, ≥2
- `clk`  in  1  single clock; all logic rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle job start; honoured only in IDLE
- `n_beats`  in  16  input beats in the job; sampled on accepted `start`
- `di`  in  B_BEAT  activation beat; pixel 0 in bits [B_PIXEL-1:0]
- `di_valid`  in  1  beat qualifier; ignored outside RUN
- `wo`  out  B_WORD  packed word; beat 0 in the lowest B_BEAT bits
- `wo_last`  out  1  marks the final word of the job
- `wo_valid`  out  1  FIFO not empty
- `wo_ready`  in  1  downstream accept
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle pulse at job end
- `overflow`  out  1  sticky; a word was dropped; cleared on accepted `start`

## Operation
- Reset values: all outputs 0; state IDLE; FIFO empty; pack register, slot index and beat counter cleared.
- States:
  - IDLE: accepted `start` clears `overflow`, the slot index and the pack register, and loads `remain = n_beats`.
    - `n_beats = 0`: go to IDLE and pulse `done` in the next cycle. No word is produced.
    - Otherwise go to RUN.
  - RUN: each `di_valid` beat is written into slot `idx` of the pack register, `idx` increments, and `remain` decrements.
    - A word completes when `idx = RATIO-1` or `remain = 1`.
    - On completion, the word is pushed into the FIFO at the same edge: `{di, pack}` with unfilled upper slots zeroed, and `last = (remain == 1)`. `idx` returns to 0.
    - Non-last completing beat with FIFO full: the word is dropped, `overflow` is set, and counting continues.
    - Last beat, FIFO not full: word pushed; go to DRAIN.
    - Last beat, FIFO full: word held in the pack register; go to FLUSH. The last word is never dropped.
  - FLUSH: push the held last word at the first edge where the FIFO is not full; go to DRAIN.
  - DRAIN: when `wo_valid & wo_ready & wo_last` pops, pulse `done` at the next cycle and go to IDLE.
- `start` outside IDLE is ignored.
- FIFO:
  - Stores `B_WORD+1` bits (word plus last flag).
  - Show-ahead: `wo`/`wo_last` are valid whenever `wo_valid` = 1.
  - Pop on `wo_valid & wo_ready`.
  - `full` is the registered count = FIFO_DEPTH. A push in the same cycle as a pop on a full FIFO is still rejected.
  - Pointers wrap modulo FIFO_DEPTH; the count is `log2(FIFO_DEPTH)+1` bits.
- `di_valid` outside RUN is discarded silently and does not set `overflow`.

## Timing
- Completing beat sampled at edge k → `wo_valid` = 1 in the cycle after edge k (latency 1) if the FIFO was empty.
- Sustained throughput: one word per RATIO beats. With `wo_ready` held high, the FIFO never exceeds 1 entry.
- `done` asserts exactly one cycle, the cycle after the edge that pops the last word. `busy` falls in the same cycle.
- `overflow` rises in the cycle after the dropping edge and holds until the next accepted `start`.
- `rst` mid-job: immediate return to IDLE with the FIFO emptied. No `done` pulse is produced.

## Test plan
- `n_beats=8`, beat i = {8{i[15:0]}}, `wo_ready`=1: two words.
  - Word 0 = beats 0..3, beat 0 in the low 128 bits.
  - `wo_last` = 1 only on word 1; `done` one cycle after word 1 pops.
- `n_beats=6`: word 1 holds beats 4 and 5 with bits [511:256] = 0 and `wo_last`=1.
- `n_beats=0`: `done` the cycle after `start`, `wo_valid` never asserts, `busy` high for one cycle.
- `wo_ready`=0, `n_beats=40` (10 words):
  - 8 words fill the FIFO; word 8 is dropped and `overflow`=1.
  - Word 9 (last) waits in FLUSH.
  - Raise `wo_ready`: 9 words out, the last with `wo_last`; then `done`.
- Full FIFO with a simultaneous pop and completing beat: the push is rejected and `overflow` is set.
- Assert `rst` for one cycle mid-RUN after 5 beats:
  - All outputs return to 0.
  - A new `start` with `n_beats=4` yields exactly one word and `overflow` stays 0.
